pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, meaning PC value loaded on reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, meaning PC loaded on trap or misaligned redirect.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  input  1  hold PC; no sequential advance.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-008 SHALL have port redirect_target  input  XLEN  branch/jump destination.
REQ-009 SHALL have port trap_valid  input  1  exception/interrupt request.
REQ-010 SHALL have port halt_req  input  1  level request to stop fetch.
REQ-011 SHALL have port instr_len2  input  1  current instruction is 16-bit; used only with PC_RVC_EN.
REQ-012 SHALL have port pc_ready  input  1  fetch stage accepts pc_out.
REQ-013 SHALL have port pc_out  output  XLEN  current fetch PC.
REQ-014 SHALL have port pc_valid  output  1  pc_out is offered to fetch.
REQ-015 SHALL have port misalign_err  output  1  one-cycle pulse on rejected redirect target.
REQ-016 SHALL have port halted  output  1  block is in HALT state.

Function
REQ-017 SHALL implement states BOOT, RUN, HALT; BOOT -> RUN unconditionally one cycle after reset release.
REQ-018 SHALL drive pc_valid=1 only in RUN; pc_valid=0 in BOOT and HALT.
REQ-019 SHALL apply next-PC priority per edge: trap_valid > redirect_valid > advance > hold.
REQ-020 SHALL, on trap_valid in any non-BOOT state, load TRAP_VECTOR next edge and enter RUN (trap exits HALT).
REQ-021 SHALL, on redirect_valid in RUN with aligned target, load redirect_target next edge regardless of stall or pc_ready.
REQ-022 SHALL treat target[1:0]!=0 as misaligned: load TRAP_VECTOR, pulse misalign_err high exactly one cycle.
REQ-023 SHALL advance (pc_out += 4) only when state=RUN, pc_valid, pc_ready, and !stall.
REQ-024 SHALL hold pc_out when stall=1 or pc_ready=0 and no trap/redirect.
REQ-025 SHALL perform increment modulo 2^XLEN; all-ones minus 3 + 4 wraps to 0 without error.
REQ-026 SHALL enter HALT from RUN on halt_req=1 at an edge with no trap/redirect; pc_out frozen.
REQ-027 SHALL return HALT -> RUN on halt_req=0; pc_out unchanged, refetches same PC.
REQ-028 SHALL ignore redirect_valid in HALT and BOOT.
REQ-029 SHALL keep halted = (state==HALT), registered, no combinational input path.

Reset
REQ-030 SHALL, on reset low, asynchronously set pc_out=RESET_VECTOR, state=BOOT, pc_valid=0, misalign_err=0, halted=0.
REQ-031 SHALL abandon any in-flight trap/redirect/halt when reset asserts mid-operation; nothing carried over.

Configuration
REQ-032 SHALL recognise macro PC_RVC_EN.
REQ-033 SHALL, with PC_RVC_EN defined, advance by 2 when instr_len2=1 else 4, and treat only target[0]!=0 as misaligned.
REQ-034 SHALL, without PC_RVC_EN, ignore instr_len2 and require target[1:0]==0.

Structure
REQ-035 SHALL take state encoding (BOOT/RUN/HALT) and increment constants from shared package pc_pkg.
REQ-036 SHALL place next-PC selection in sub-module pc_next_mux (combinational); pc_gen holds registers and FSM.

Verification
REQ-037 SHALL test: reset low then high, pc_ready=1 -> pc_out 0, pc_valid 0 for one cycle, then 0,4,8,C.
REQ-038 SHALL test: redirect to 0x40 with stall=1 -> pc_out=0x40 next cycle; held while stall=1.
REQ-039 SHALL test: redirect to 0x42 (no RVC) -> pc_out=0x100, misalign_err high one cycle.
REQ-040 SHALL test: simultaneous trap_valid and redirect 0x80 -> pc_out=0x100.
REQ-041 SHALL test: halt_req at pc 0x10, hold 5 cycles, release -> halted 1, pc_valid 0, then RUN at 0x10; XLEN=8 from 0xFC -> 0x00.
REQ-042 SHALL test: PC_RVC_EN, instr_len2 pattern 1,0,1 from 0 -> 0,2,6,8; reset mid-stall -> RESET_VECTOR immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// ----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter generator.
//   pc_state_e   : FSM state encoding (BOOT / RUN / HALT)
//   PC_INC_WORD  : sequential step for a 32-bit instruction
//   PC_INC_HALF  : sequential step for a 16-bit instruction (PC_RVC_EN builds)
// ----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam int unsigned PC_INC_WORD = 4;
    localparam int unsigned PC_INC_HALF = 2;

endpackage : pc_pkg

// File: rtl/pc_next_mux.sv
// ----------------------------------------------------------------------------
// pc_next_mux
// Combinational next-PC selection. Priority: trap > redirect > advance > hold.
// A misaligned redirect target is replaced by TRAP_VECTOR and flagged.
//
// Optional feature macro: PC_RVC_EN
//   defined   : step is 2 when instr_len2_i=1, else 4; only target[0] must be 0
//   undefined : step is always 4; target[1:0] must be 0; instr_len2_i ignored
//
// Ports
//   pc_i              current PC
//   trap_take_i       trap accepted this cycle
//   redirect_take_i   redirect accepted this cycle
//   advance_i         sequential advance allowed this cycle
//   redirect_target_i redirect destination
//   instr_len2_i      current instruction is 16-bit
//   pc_next_o         PC to load at the next edge
//   misalign_o        redirect rejected because of target alignment
// ----------------------------------------------------------------------------
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  TRAP_VECTOR = XLEN'(32'h0000_0100)
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            trap_take_i,
    input  logic            redirect_take_i,
    input  logic            advance_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            instr_len2_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] step;
    logic            target_misaligned;

`ifdef PC_RVC_EN
    assign step              = instr_len2_i ? XLEN'(PC_INC_HALF) : XLEN'(PC_INC_WORD);
    assign target_misaligned = redirect_target_i[0];
`else
    // Length hint has no meaning without compressed instructions.
    logic unused_len2;
    assign unused_len2       = instr_len2_i;
    assign step              = XLEN'(PC_INC_WORD);
    assign target_misaligned = |redirect_target_i[1:0];
`endif

    always_comb begin
        pc_next_o  = pc_i;
        misalign_o = 1'b0;
        if (trap_take_i) begin
            pc_next_o = TRAP_VECTOR;
        end else if (redirect_take_i) begin
            if (target_misaligned) begin
                pc_next_o  = TRAP_VECTOR;
                misalign_o = 1'b1;
            end else begin
                pc_next_o = redirect_target_i;
            end
        end else if (advance_i) begin
            // Natural XLEN-bit wrap: top-of-memory + step rolls over to 0.
            pc_next_o = pc_i + step;
        end
    end

endmodule : pc_next_mux

// File: rtl/pc_gen.sv
// ----------------------------------------------------------------------------
// pc_gen
// Program-counter generator: BOOT/RUN/HALT control FSM plus PC and
// misalign-pulse registers. Next-PC selection lives in pc_next_mux.
//
// Optional feature macro: PC_RVC_EN (16-bit instruction support, see
// pc_next_mux).
//
// Ports
//   clk              single clock, rising edge
//   reset            asynchronous active-low reset
//   stall            hold PC, no sequential advance
//   redirect_valid   branch/jump taken this cycle (RUN only)
//   redirect_target  branch/jump destination
//   trap_valid       exception/interrupt request (RUN or HALT)
//   halt_req         level request to stop fetch
//   instr_len2       current instruction is 16-bit (PC_RVC_EN only)
//   pc_ready         fetch accepts pc_out
//   pc_out           current fetch PC
//   pc_valid         pc_out offered to fetch (RUN only)
//   misalign_err     one-cycle pulse on a rejected redirect target
//   halted           block is in HALT (registered state decode)
// ----------------------------------------------------------------------------
module pc_gen
    import pc_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic            halt_req,
    input  logic            instr_len2,
    input  logic            pc_ready,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            misalign_err,
    output logic            halted
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            merr_q, merr_d;

    logic            trap_take;
    logic            redirect_take;
    logic            advance;

    always_comb begin
        state_d       = state_q;
        trap_take     = 1'b0;
        redirect_take = 1'b0;
        advance       = 1'b0;
        pc_valid      = (state_q == ST_RUN);
        halted        = (state_q == ST_HALT);
        unique case (state_q)
            // BOOT ignores every request; it only gives reset one quiet cycle.
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (trap_valid) begin
                    trap_take = 1'b1;
                end else if (redirect_valid) begin
                    redirect_take = 1'b1;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else begin
                    advance = pc_ready && !stall;
                end
            end
            ST_HALT: begin
                // Redirects are dropped here; only a trap or release leaves.
                if (trap_valid) begin
                    trap_take = 1'b1;
                    state_d   = ST_RUN;
                end else if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    pc_next_mux #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next (
        .pc_i              (pc_q),
        .trap_take_i       (trap_take),
        .redirect_take_i   (redirect_take),
        .advance_i         (advance),
        .redirect_target_i (redirect_target),
        .instr_len2_i      (instr_len2),
        .pc_next_o         (pc_d),
        .misalign_o        (merr_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            merr_q  <= merr_d;
        end
    end

    assign pc_out       = pc_q;
    assign misalign_err = merr_q;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        stall, redirect_valid, trap_valid, halt_req, instr_len2, pc_ready;
    logic [31:0] redirect_target;
    logic [31:0] pc_out;
    logic        pc_valid, misalign_err, halted;

    // Narrow instance for the wrap-around check.
    logic        s8_stall, s8_rv, s8_trap, s8_halt, s8_len2, s8_rdy;
    logic [7:0]  s8_tgt;
    logic [7:0]  s8_pc;
    logic        s8_vld, s8_merr, s8_halted;

    int total = 0;
    int bad   = 0;

`ifdef PC_RVC_EN
    localparam logic [31:0] L2INC    = 32'd2;
    localparam logic [31:0] PC_AT42  = 32'h42;
    localparam logic        MERR_42  = 1'b0;
    localparam logic [31:0] PC_AFT42 = 32'h46;
`else
    localparam logic [31:0] L2INC    = 32'd4;
    localparam logic [31:0] PC_AT42  = 32'h100;
    localparam logic        MERR_42  = 1'b1;
    localparam logic [31:0] PC_AFT42 = 32'h104;
`endif

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .halt_req        (halt_req),
        .instr_len2      (instr_len2),
        .pc_ready        (pc_ready),
        .pc_out          (pc_out),
        .pc_valid        (pc_valid),
        .misalign_err    (misalign_err),
        .halted          (halted)
    );

    pc_gen #(.XLEN(8), .RESET_VECTOR(8'h0), .TRAP_VECTOR(8'h80)) dut8 (
        .clk             (clk),
        .reset           (reset),
        .stall           (s8_stall),
        .redirect_valid  (s8_rv),
        .redirect_target (s8_tgt),
        .trap_valid      (s8_trap),
        .halt_req        (s8_halt),
        .instr_len2      (s8_len2),
        .pc_ready        (s8_rdy),
        .pc_out          (s8_pc),
        .pc_valid        (s8_vld),
        .misalign_err    (s8_merr),
        .halted          (s8_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic        trap;
        logic        halt;
        logic        len2;
        logic        rdy;
        logic [31:0] epc;
        logic        evld;
        logic        emerr;
        logic        ehalt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic st, input logic rv, input logic [31:0] tgt,
                       input logic tr, input logic hl, input logic l2, input logic rd,
                       input logic [31:0] epc, input logic ev, input logic em,
                       input logic eh);
        vec_t v;
        v.stall = st; v.rv = rv; v.tgt = tgt; v.trap = tr; v.halt = hl;
        v.len2 = l2; v.rdy = rd; v.epc = epc; v.evld = ev; v.emerr = em; v.ehalt = eh;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [31:0] epc, input logic ev,
                           input logic em, input logic eh);
        chk({name, ".pc"},     pc_out,              epc);
        chk({name, ".valid"},  {31'd0, pc_valid},     {31'd0, ev});
        chk({name, ".merr"},   {31'd0, misalign_err}, {31'd0, em});
        chk({name, ".halted"}, {31'd0, halted},       {31'd0, eh});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rv, input logic [31:0] tgt,
                         input logic tr, input logic hl, input logic l2, input logic rd);
        stall = st; redirect_valid = rv; redirect_target = tgt;
        trap_valid = tr; halt_req = hl; instr_len2 = l2; pc_ready = rd;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 0, 1);
        s8_stall = 0; s8_rv = 0; s8_tgt = 8'h0; s8_trap = 0; s8_halt = 0;
        s8_len2 = 0; s8_rdy = 0;

        // Vector table: inputs for one edge, then expected outputs after it.
        //   st rv tgt        tr hl l2 rd   pc        vld merr halt
        add(0, 0, 32'h0,     0, 0, 0, 1,  32'h0,    1, 0, 0); // BOOT -> RUN
        add(0, 0, 32'h0,     0, 0, 0, 1,  32'h4,    1, 0, 0);
        add(0, 0, 32'h0,     0, 0, 0, 1,  32'h8,    1, 0, 0);
        add(0, 0, 32'h0,     0, 0, 0, 1,  32'hC,    1, 0, 0);
        add(0, 0, 32'h0,     0, 0, 0, 1,  32'h10,   1, 0, 0);
        add(0, 0, 32'h0,     0, 1, 0, 1,  32'h10,   0, 0, 1); // enter HALT
        add(0, 0, 32'h0,     0, 1, 0, 1,  32'h10,   0, 0, 1);
        add(0, 0, 32'h0,     0, 1, 0, 1,  32'h10,   0, 0, 1);
        add(0, 0, 32'h0,     0, 1, 0, 1,  32'h10,   0, 0, 1);
        add(0, 0, 32'h0,     0, 1, 0, 1,  32'h10,   0, 0, 1);
        add(0, 1, 32'h80,    0, 1, 0, 1,  32'h10,   0, 0, 1); // redirect ignored in HALT
        add(0, 0, 32'h0,     0, 0, 0, 1,  32'h10,   1, 0, 0); // release, refetch 0x10
        add(0, 0, 32'h0,     0, 0, 0, 1,  32'h14,   1, 0, 0);
        add(0, 0, 32'h0,     0, 0, 0, 0,  32'h14,   1, 0, 0); // not ready
        add(1, 0, 32'h0,     0, 0, 0, 1,  32'h14,   1, 0, 0); // stall
        add(1, 1, 32'h40,    0, 0, 0, 1,  32'h40,   1, 0, 0); // redirect under stall
        add(1, 0, 32'h0,     0, 0, 0, 1,  32'h40,   1, 0, 0);
        add(1, 0, 32'h0,     0, 0, 0, 1,  32'h40,   1, 0, 0);
        add(0, 0, 32'h0,     0, 0, 0, 1,  32'h44,   1, 0, 0);
        add(0, 1, 32'h42,    0, 0, 0, 1,  PC_AT42,  1, MERR_42, 0);
        add(0, 0, 32'h0,     0, 0, 0, 1,  PC_AFT42, 1, 0, 0);
        add(0, 1, 32'h80,    1, 0, 0, 1,  32'h100,  1, 0, 0); // trap beats redirect
        add(0, 0, 32'h0,     0, 0, 0, 1,  32'h104,  1, 0, 0);
        add(0, 1, 32'h80,    0, 0, 0, 0,  32'h80,   1, 0, 0); // redirect without ready
        add(0, 0, 32'h0,     0, 1, 0, 1,  32'h80,   0, 0, 1);
        add(0, 0, 32'h0,     1, 1, 0, 1,  32'h100,  1, 0, 0); // trap exits HALT
        add(0, 0, 32'h0,     0, 0, 0, 1,  32'h104,  1, 0, 0);
        add(0, 0, 32'h0,     0, 0, 1, 1,  32'h104 + L2INC, 1, 0, 0);
        add(0, 1, 32'h43,    0, 0, 0, 1,  32'h100,  1, 1, 0); // misaligned either way
        add(0, 0, 32'h0,     0, 0, 0, 1,  32'h104,  1, 0, 0);

        step();
        step();
        chk_all("reset_hold", 32'h0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk_all("boot", 32'h0, 0, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].stall, vt[i].rv, vt[i].tgt, vt[i].trap, vt[i].halt,
                  vt[i].len2, vt[i].rdy);
            step();
            chk_all($sformatf("vec%0d", i), vt[i].epc, vt[i].evld, vt[i].emerr,
                    vt[i].ehalt);
        end

        // Reset asserted in the middle of a stalled cycle, with requests pending.
        drive(1, 1, 32'h80, 1, 1, 0, 1);
        step();
        chk_all("stall_pre_reset", 32'h100, 1, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 32'h0, 0, 0, 0);
        step();
        chk_all("reset_held", 32'h0, 0, 0, 0);
        reset = 1'b1;
        step();
        chk_all("boot_ignores_req", 32'h0, 1, 0, 0);

        // Instruction-length pattern 1,0,1 from 0.
        drive(0, 0, 32'h0, 0, 0, 1, 1);
        step();
        chk_all("len2_a", L2INC, 1, 0, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 1);
        step();
        chk_all("len2_b", L2INC + 32'd4, 1, 0, 0);
        drive(0, 0, 32'h0, 0, 0, 1, 1);
        step();
        chk_all("len2_c", L2INC + L2INC + 32'd4, 1, 0, 0);

        // XLEN=8: wrap from 0xFC and trap-vector on misaligned redirect.
        chk("x8_idle", {24'd0, s8_pc}, 32'h0);
        s8_rv = 1; s8_tgt = 8'hFC;
        step();
        chk("x8_redir", {24'd0, s8_pc}, 32'hFC);
        s8_rv = 0; s8_rdy = 1;
        step();
        chk("x8_wrap", {24'd0, s8_pc}, 32'h00);
        chk("x8_wrap_merr", {31'd0, s8_merr}, 32'h0);
        step();
        chk("x8_after_wrap", {24'd0, s8_pc}, 32'h04);
        s8_rv = 1; s8_tgt = 8'h03;
        step();
        chk("x8_misalign_pc", {24'd0, s8_pc}, 32'h80);
        chk("x8_misalign_merr", {31'd0, s8_merr}, 32'h1);
        s8_rv = 0;
        step();
        chk("x8_merr_pulse", {31'd0, s8_merr}, 32'h0);
        chk("x8_post", {24'd0, s8_pc}, 32'h84);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_gen
